// File: rtl/vend_ctrl.sv
// Multi-product vending controller: credit accumulation, vend handshake, coin-by-coin change return.
// Optional inactivity auto-cancel is enabled by defining VEND_TIMEOUT_EN.
module vend_ctrl #(
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned CREDIT_MAX  = 40,
  parameter int unsigned N_DRINK     = 4,
  parameter int unsigned PRICE_W     = 6,
  parameter logic [N_DRINK*PRICE_W-1:0] DRINK_PRICES = {6'd20, 6'd15, 6'd10, 6'd5},
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_insert,
  input  logic [1:0]          coin_val,
  input  logic [N_DRINK-1:0]  drink_req,
  input  logic                cancel,
  input  logic                vend_ack,
  input  logic                change_ack,
  output logic                hold_ind,
  output logic [N_DRINK-1:0]  drink_avail,
  output logic                vend_req,
  output logic [N_DRINK-1:0]  vend_id,
  output logic                change_req,
  output logic [1:0]          change_coin,
  output logic                coin_reject,
  output logic                timeout_evt,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0] MAX_EXT = SUM_W'(CREDIT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t               state, state_nxt;
  logic [CREDIT_W-1:0]  credit_nxt;
  logic                 vend_req_nxt;
  logic [N_DRINK-1:0]   vend_id_nxt;
  logic                 change_req_nxt;
  logic [1:0]           change_coin_nxt;
  logic                 coin_reject_nxt;
  logic                 timeout_nxt;

  logic [CREDIT_W-1:0]  price [N_DRINK];
  logic [CREDIT_W-1:0]  coin_units;
  logic                 coin_ok;
  logic                 sel_hit;
  logic [N_DRINK-1:0]   sel_id;
  logic [CREDIT_W-1:0]  sel_price;
  logic [CREDIT_W-1:0]  change_units;
  logic [CREDIT_W-1:0]  change_rem;
  logic                 tmo_fire;

  for (genvar g = 0; g < N_DRINK; g++) begin : g_price
    assign price[g]       = CREDIT_W'(DRINK_PRICES[g*PRICE_W +: PRICE_W]);
    assign drink_avail[g] = (state == S_CREDIT) && (credit >= price[g]);
  end

  assign hold_ind = (state != S_IDLE);

  function automatic logic [1:0] coin_for(input logic [CREDIT_W-1:0] c);
    return (c >= CREDIT_W'(2)) ? 2'b01 : 2'b11;
  endfunction

  // Coin decode and ceiling check in one extra bit so overflow cannot wrap
  always_comb begin
    coin_units = '0;
    case (coin_val)
      2'b01:   coin_units = CREDIT_W'(2);
      2'b10:   coin_units = CREDIT_W'(20);
      2'b11:   coin_units = CREDIT_W'(1);
      default: coin_units = '0;
    endcase
    coin_ok = (coin_val != 2'b00) &&
              ((SUM_W'(credit) + SUM_W'(coin_units)) <= MAX_EXT);
  end

  // Lowest-index requested product that is currently affordable
  always_comb begin
    sel_hit   = 1'b0;
    sel_id    = '0;
    sel_price = '0;
    for (int i = 0; i < N_DRINK; i++) begin
      if (!sel_hit && drink_req[i] && drink_avail[i]) begin
        sel_hit   = 1'b1;
        sel_id[i] = 1'b1;
        sel_price = price[i];
      end
    end
  end

  assign change_units = (change_coin == 2'b01) ? CREDIT_W'(2) : CREDIT_W'(1);
  assign change_rem   = credit - change_units;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             activity;

  always_comb begin
    activity    = coin_insert || (drink_req != '0) || cancel;
    tmo_fire    = (state == S_CREDIT) && !activity && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    tmo_cnt_nxt = (state != S_CREDIT || activity || tmo_fire) ? '0 : tmo_cnt + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt <= '0;
    else        tmo_cnt <= tmo_cnt_nxt;
  end
`else
  // Timeout disabled: the limit parameter has no effect
  assign tmo_fire = (TIMEOUT_CYC == 0) & 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      credit      <= '0;
      vend_req    <= 1'b0;
      vend_id     <= '0;
      change_req  <= 1'b0;
      change_coin <= 2'b00;
      coin_reject <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      vend_req    <= vend_req_nxt;
      vend_id     <= vend_id_nxt;
      change_req  <= change_req_nxt;
      change_coin <= change_coin_nxt;
      coin_reject <= coin_reject_nxt;
      timeout_evt <= timeout_nxt;
    end
  end

  // A drink_req that selects nothing is ignored entirely, so a coin in the same cycle still counts
  always_comb begin
    state_nxt       = state;
    credit_nxt      = credit;
    vend_req_nxt    = vend_req;
    vend_id_nxt     = vend_id;
    change_req_nxt  = change_req;
    change_coin_nxt = change_coin;
    coin_reject_nxt = 1'b0;
    timeout_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (coin_insert) begin
          if (coin_ok) begin
            credit_nxt = credit + coin_units;
            state_nxt  = S_CREDIT;
          end else begin
            coin_reject_nxt = 1'b1;
          end
        end
      end
      S_CREDIT: begin
        if (cancel || tmo_fire) begin
          state_nxt       = S_CHANGE;
          change_req_nxt  = 1'b1;
          change_coin_nxt = coin_for(credit);
          timeout_nxt     = tmo_fire;
          coin_reject_nxt = coin_insert;
        end else if (sel_hit) begin
          credit_nxt      = credit - sel_price;
          vend_req_nxt    = 1'b1;
          vend_id_nxt     = sel_id;
          state_nxt       = S_VEND;
          coin_reject_nxt = coin_insert;
        end else if (coin_insert) begin
          if (coin_ok) credit_nxt = credit + coin_units;
          else         coin_reject_nxt = 1'b1;
        end
      end
      S_VEND: begin
        coin_reject_nxt = coin_insert;
        if (vend_ack) begin
          vend_req_nxt = 1'b0;
          vend_id_nxt  = '0;
          if (credit == '0) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt       = S_CHANGE;
            change_req_nxt  = 1'b1;
            change_coin_nxt = coin_for(credit);
          end
        end
      end
      S_CHANGE: begin
        coin_reject_nxt = coin_insert;
        if (change_ack) begin
          credit_nxt = change_rem;
          if (change_rem == '0) begin
            state_nxt       = S_IDLE;
            change_req_nxt  = 1'b0;
            change_coin_nxt = 2'b00;
          end else begin
            change_coin_nxt = coin_for(change_rem);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural credit/phase model.
module tb_vend_ctrl;

`ifdef VEND_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 1000;
`endif
  localparam int P_IDLE = 0, P_CREDIT = 1, P_VEND = 2, P_CHANGE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_insert = 1'b0;
  logic [1:0] coin_val = 2'b00;
  logic [3:0] drink_req = 4'b0000;
  logic       cancel = 1'b0;
  logic       vend_ack = 1'b0;
  logic       change_ack = 1'b0;
  logic       hold_ind;
  logic [3:0] drink_avail;
  logic       vend_req;
  logic [3:0] vend_id;
  logic       change_req;
  logic [1:0] change_coin;
  logic       coin_reject;
  logic       timeout_evt;
  logic [7:0] credit;

  vend_ctrl #(.TIMEOUT_CYC(TB_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .coin_insert(coin_insert), .coin_val(coin_val),
    .drink_req(drink_req), .cancel(cancel), .vend_ack(vend_ack), .change_ack(change_ack),
    .hold_ind(hold_ind), .drink_avail(drink_avail), .vend_req(vend_req), .vend_id(vend_id),
    .change_req(change_req), .change_coin(change_coin), .coin_reject(coin_reject),
    .timeout_evt(timeout_evt), .credit(credit)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: machine phase, credit in half-yuan units, last vended product
  int PRICE [4] = '{5, 10, 15, 20};
  int m_phase  = P_IDLE;
  int m_credit = 0;
  int m_vid    = 0;
  int m_tcnt   = 0;
  bit m_rej    = 0;
  bit m_tmo    = 0;
  int m_v, m_pick;
  bit m_act;

  function automatic int units_of(input logic [1:0] c);
    case (c)
      2'b01:   return 2;
      2'b10:   return 20;
      2'b11:   return 1;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_credit = 0; m_vid = 0; m_tcnt = 0; m_rej = 0; m_tmo = 0;
    end else begin
      m_rej = 0;
      m_tmo = 0;
      m_v   = units_of(coin_val);
      m_act = coin_insert || (drink_req != 0) || cancel;
      case (m_phase)
        P_IDLE: begin
          if (coin_insert) begin
            if (m_v > 0 && m_credit + m_v <= 40) begin
              m_credit += m_v;
              m_phase = P_CREDIT;
            end else m_rej = 1;
          end
        end
        P_CREDIT: begin
          m_pick = -1;
          for (int i = 3; i >= 0; i--)
            if (drink_req[i] && m_credit >= PRICE[i]) m_pick = i;
          if (cancel) begin
            m_phase = P_CHANGE;
            m_rej = coin_insert;
          end else if (m_pick >= 0) begin
            m_credit -= PRICE[m_pick];
            m_vid = m_pick;
            m_phase = P_VEND;
            m_rej = coin_insert;
          end else if (`ifdef VEND_TIMEOUT_EN !m_act && m_tcnt == TB_TMO - 1 `else 1'b0 `endif) begin
            m_phase = P_CHANGE;
            m_tmo = 1;
          end else if (coin_insert) begin
            if (m_v > 0 && m_credit + m_v <= 40) m_credit += m_v;
            else m_rej = 1;
          end
          if (m_act || m_phase != P_CREDIT) m_tcnt = 0;
          else m_tcnt++;
        end
        P_VEND: begin
          m_rej = coin_insert;
          if (vend_ack) m_phase = (m_credit == 0) ? P_IDLE : P_CHANGE;
        end
        default: begin
          m_rej = coin_insert;
          if (change_ack) begin
            m_credit -= (m_credit >= 2) ? 2 : 1;
            if (m_credit == 0) m_phase = P_IDLE;
          end
        end
      endcase
      if (m_phase != P_CREDIT) m_tcnt = 0;
    end
  end

  // Per-cycle comparison of every output against the model
  logic [3:0] e_avail;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 4; i++) e_avail[i] = (m_phase == P_CREDIT) && (m_credit >= PRICE[i]);
      chk("m_hold_ind", hold_ind, m_phase != P_IDLE);
      chk("m_drink_avail", drink_avail, e_avail);
      chk("m_vend_req", vend_req, m_phase == P_VEND);
      chk("m_vend_id", vend_id, (m_phase == P_VEND) ? (32'd1 << m_vid) : 32'd0);
      chk("m_change_req", change_req, m_phase == P_CHANGE);
      chk("m_change_coin", change_coin,
          (m_phase != P_CHANGE) ? 32'd0 : ((m_credit >= 2) ? 32'd1 : 32'd3));
      chk("m_coin_reject", coin_reject, m_rej);
      chk("m_timeout_evt", timeout_evt, m_tmo);
      chk("m_credit", credit, m_credit);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic coin(input logic [1:0] v);
    coin_insert = 1'b1; coin_val = v;
    tick();
    coin_insert = 1'b0; coin_val = 2'b00;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 40 && change_req; k++) begin
      change_ack = 1'b1;
      tick();
    end
    change_ack = 1'b0;
    chk(nm, {hold_ind, change_req}, 2'b00);
  endtask

  logic [1:0] exp_seq [3];
  int         n_wait;

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
    chk("reset_credit", credit, 0);
    chk("reset_hold", hold_ind, 0);
    chk("reset_vend_req", vend_req, 0);
    chk("reset_change_req", change_req, 0);

    // Normal vend with half-yuan change
    coin(2'b01); coin(2'b01); coin(2'b01);
    chk("nv_credit", credit, 6);
    chk("nv_avail", drink_avail, 4'b0001);
    drink_req = 4'b0010; tick(); drink_req = 4'b0000;
    chk("nv_unaffordable_ignored", {vend_req, credit}, {1'b0, 8'd6});
    drink_req = 4'b0001; tick(); drink_req = 4'b0000;
    chk("nv_vend", {vend_req, vend_id, credit}, {1'b1, 4'b0001, 8'd1});
    vend_ack = 1'b1; tick(); vend_ack = 1'b0;
    chk("nv_change", {vend_req, change_req, change_coin}, {1'b0, 1'b1, 2'b11});
    change_ack = 1'b1; tick(); change_ack = 1'b0;
    chk("nv_done", {hold_ind, change_req, credit}, {1'b0, 1'b0, 8'd0});

    // Credit ceiling, then ten 1-yuan coins of change
    coin(2'b10); coin(2'b10);
    chk("ceil_credit", credit, 40);
    coin(2'b01);
    chk("ceil_reject", {coin_reject, credit}, {1'b1, 8'd40});
    drink_req = 4'b1000; tick(); drink_req = 4'b0000;
    chk("ceil_vend", {vend_id, credit}, {4'b1000, 8'd20});
    vend_ack = 1'b1; tick(); vend_ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("ceil_change_coin", {change_req, change_coin}, {1'b1, 2'b01});
      change_ack = 1'b1; tick();
    end
    change_ack = 1'b0;
    chk("ceil_done", {hold_ind, credit}, {1'b0, 8'd0});

    // Cancel beats drink_req in the same cycle
    coin(2'b01); coin(2'b01); coin(2'b11);
    cancel = 1'b1; drink_req = 4'b0001; tick(); cancel = 1'b0; drink_req = 4'b0000;
    chk("cx_no_vend", {vend_req, change_req, credit}, {1'b0, 1'b1, 8'd5});
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      chk("cx_coin", change_coin, exp_seq[k]);
      change_ack = 1'b1; tick(); change_ack = 1'b0;
    end
    chk("cx_done", {hold_ind, credit}, {1'b0, 8'd0});

    // Coin arriving during a vend is rejected
    coin(2'b10);
    drink_req = 4'b0001; tick(); drink_req = 4'b0000;
    coin(2'b01);
    chk("cv_reject", {coin_reject, vend_req, credit}, {1'b1, 1'b1, 8'd15});
    vend_ack = 1'b1; tick(); vend_ack = 1'b0;
    chk("cv_change", {change_req, credit}, {1'b1, 8'd15});
    drain("cv_drain");

    // Asynchronous reset while returning change
    coin(2'b01); coin(2'b01); coin(2'b01); coin(2'b11);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("rst_pre", {change_req, change_coin, credit}, {1'b1, 2'b01, 8'd7});
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outputs",
           {hold_ind, drink_avail, vend_req, vend_id, change_req, change_coin, coin_reject, timeout_evt, credit},
           '0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("rst_after", {hold_ind, change_req, credit}, {1'b0, 1'b0, 8'd0});

`ifdef VEND_TIMEOUT_EN
    // Idle session times out; a coin partway restarts the count
    coin(2'b01);
    repeat (10) tick();
    chk("tmo_not_yet", {timeout_evt, change_req}, 2'b00);
    coin(2'b11);
    n_wait = 0;
    for (int k = 0; k < 40 && !timeout_evt; k++) begin
      tick();
      n_wait++;
    end
    chk("tmo_cycles", n_wait, 16);
    chk("tmo_change", {timeout_evt, change_req, change_coin, credit}, {1'b1, 1'b1, 2'b01, 8'd3});
    drain("tmo_drain");
`endif

    // Randomized traffic, checked every cycle by the model comparator
    for (int c = 0; c < 3000; c++) begin
      coin_insert = ($urandom_range(0, 3) == 0);
      coin_val    = 2'($urandom_range(0, 3));
      drink_req   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      cancel      = ($urandom_range(0, 19) == 0);
      vend_ack    = ($urandom_range(0, 2) == 0);
      change_ack  = ($urandom_range(0, 1) == 0);
      tick();
    end
    coin_insert = 1'b0; drink_req = 4'b0000; cancel = 1'b0;
    vend_ack = 1'b1;
    tick();
    vend_ack = 1'b0;
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
